abc_rr_scheduler: RTL and testbench

ABC_RR_SCHEDULER -- requirements
Module: abc_rr_scheduler

---
 rtl/abc_rr_scheduler_if.sv | 29 ++
 rtl/abc_rr_scheduler.sv | 141 ++++++++++++++
 tb/tb_abc_rr_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/abc_rr_scheduler_if.sv
// Requester/evaluator bundle for the round-robin scheduler.
// The slave side is the scheduler; the master side drives requests and d_i.
interface abc_rr_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] opnd;
  logic [NREQ-1:0]   gnt;
  logic              a_o;
  logic              b_o;
  logic              c_o;
  logic              d_i;
  logic              res_valid;
  logic              res_d;
  logic [1:0]        res_id;
  logic              busy;

  modport master (
    output req, opnd, d_i,
    input  gnt, a_o, b_o, c_o,
    input  res_valid, res_d, res_id, busy
  );

  modport slave (
    input  req, opnd, d_i,
    output gnt, a_o, b_o, c_o,
    output res_valid, res_d, res_id, busy
  );
endinterface

// File: rtl/abc_rr_scheduler.sv
// Round-robin scheduler sharing one combinational {a,b,c}->d evaluator
// among NREQ requesters; operands are held for SETTLE cycles before d_i is sampled.
module abc_rr_scheduler #(
  parameter int NREQ   = 3,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic reset,
  abc_rr_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic            a_q, a_d;
  logic            b_q, b_d;
  logic            c_q, c_d;
  logic            rv_q, rv_d;
  logic            rd_q, rd_d;
  logic [1:0]      rid_q, rid_d;

  logic [3:0]      req4;
  logic [2:0]      scan;
  logic [1:0]      win;
  logic            hit;
  logic [2:0]      sel;
  logic [NREQ-1:0] gnt_c;
  logic            busy_c;

  // Scan last+1, last+2, ... modulo NREQ; first set request wins.
  always_comb begin
    req4 = 4'(bus.req);
    scan = '0;
    win  = last_q;
    hit  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, last_q} + 3'(k);
      if (scan >= 3'(NREQ)) scan = scan - 3'(NREQ);
      if (!hit && req4[scan[1:0]]) begin
        hit = 1'b1;
        win = scan[1:0];
      end
    end
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) sel = bus.opnd[3*i +: 3];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit) state_d = DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The grant is decoded from the owner index so it can never be multi-hot.
  always_comb begin
    busy_c = (state_q == DRIVE);
    gnt_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_c[i] = busy_c && (last_q == 2'(i));
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    rv_d   = 1'b0;
    rd_d   = rd_q;
    rid_d  = rid_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          last_d        = win;
          {a_d,b_d,c_d} = sel;
          cnt_d         = CW'(SETTLE - 1);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          rv_d  = 1'b1;
          rd_d  = bus.d_i;
          rid_d = last_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 2'(NREQ - 1);
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      c_q    <= 1'b0;
      rv_q   <= 1'b0;
      rd_q   <= 1'b0;
      rid_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      rv_q   <= rv_d;
      rd_q   <= rd_d;
      rid_q  <= rid_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.busy      = busy_c;
  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.c_o       = c_q;
  assign bus.res_valid = rv_q;
  assign bus.res_d     = rd_q;
  assign bus.res_id    = rid_q;

endmodule

// File: tb/tb_abc_rr_scheduler.sv
// Bench for abc_rr_scheduler: SETTLE=1 and SETTLE=3 instances share stimulus;
// a transaction-level model fills queues that per-DUT monitors drain.
module tb_abc_rr_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] req_s;
  logic [8:0] opnd_s;

  abc_rr_scheduler_if #(.NREQ(3)) bus1 ();
  abc_rr_scheduler_if #(.NREQ(3)) bus3 ();

  assign bus1.req  = req_s;
  assign bus1.opnd = opnd_s;
  assign bus1.d_i  = (bus1.a_o | bus1.b_o) & bus1.c_o;
  assign bus3.req  = req_s;
  assign bus3.opnd = opnd_s;
  assign bus3.d_i  = (bus3.a_o | bus3.b_o) & bus3.c_o;

  abc_rr_scheduler #(.NREQ(3), .SETTLE(1)) u1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );
  abc_rr_scheduler #(.NREQ(3), .SETTLE(3)) u3 (
    .clk(clk), .reset(rst), .bus(bus3)
  );

  int total = 0;
  int bad   = 0;

  logic [5:0] gq0[$], gq1[$];
  logic [2:0] rq0[$], rq1[$];

  int         m_left[2] = '{0, 0};
  int         m_last[2] = '{2, 2};
  logic       m_rd[2]   = '{1'b0, 1'b0};
  logic [2:0] m_abc[2]  = '{3'b0, 3'b0};
  logic [2:0] g_prev[2] = '{3'b0, 3'b0};
  int         g_len[2]  = '{0, 0};

  function automatic int stl(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input int k, input string nm,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got=%0h want=%0h", k, nm, got, exp);
    end
  endtask

  // One clock edge of the scheduling rules, at transaction level.
  task automatic model_step(input int k, input logic [2:0] r,
                            input logic [8:0] o);
    int w;
    logic [2:0] ops;
    if (m_left[k] > 0) begin
      m_left[k]--;
    end else if (r != 3'b000) begin
      w = -1;
      for (int j = 1; j <= 3; j++) begin
        if (w < 0 && r[(m_last[k] + j) % 3]) w = (m_last[k] + j) % 3;
      end
      ops       = 3'(o >> (3 * w));
      m_last[k] = w;
      m_left[k] = stl(k);
      if (k == 0) begin
        gq0.push_back({3'(1 << w), ops});
        rq0.push_back({(ops[2] | ops[1]) & ops[0], 2'(w)});
      end else begin
        gq1.push_back({3'(1 << w), ops});
        rq1.push_back({(ops[2] | ops[1]) & ops[0], 2'(w)});
      end
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [8:0] o);
    req_s  = r;
    opnd_s = o;
    model_step(0, r, o);
    model_step(1, r, o);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(3'b000, 9'd0);
  endtask

  task automatic mon(input int k, input logic [2:0] g,
                     input logic a, input logic b, input logic c,
                     input logic rv, input logic rd,
                     input logic [1:0] rid, input logic bsy);
    logic [5:0] eg;
    logic [2:0] er;
    logic       empty;
    chk(k, "onehot0", 32'($onehot0(g)), 1);
    chk(k, "busy", bsy, g != 3'b000);
    if (g != 3'b000 && g_prev[k] == 3'b000) begin
      empty = (k == 0) ? (gq0.size() == 0) : (gq1.size() == 0);
      if (empty) begin
        chk(k, "unexpected_grant", 1, 0);
      end else begin
        eg = (k == 0) ? gq0.pop_front() : gq1.pop_front();
        chk(k, "gnt", g, eg[5:3]);
        chk(k, "abc", {a, b, c}, eg[2:0]);
        m_abc[k] = eg[2:0];
      end
    end
    if (g == 3'b000) chk(k, "abc_hold", {a, b, c}, m_abc[k]);
    if (g != 3'b000) begin
      g_len[k]++;
    end else if (g_prev[k] != 3'b000) begin
      chk(k, "gnt_len", g_len[k], stl(k));
      g_len[k] = 0;
    end
    if (rv) begin
      empty = (k == 0) ? (rq0.size() == 0) : (rq1.size() == 0);
      if (empty) begin
        chk(k, "unexpected_strobe", 1, 0);
      end else begin
        er = (k == 0) ? rq0.pop_front() : rq1.pop_front();
        chk(k, "res_d", rd, er[2]);
        chk(k, "res_id", rid, er[1:0]);
        m_rd[k] = er[2];
      end
    end else begin
      chk(k, "res_hold", rd, m_rd[k]);
    end
    g_prev[k] = g;
  endtask

  task automatic mon_reset(input int k);
    g_prev[k] = 3'b000;
    g_len[k]  = 0;
    m_rd[k]   = 1'b0;
    m_abc[k]  = 3'b000;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_reset(0);
      mon_reset(1);
    end else begin
      mon(0, bus1.gnt, bus1.a_o, bus1.b_o, bus1.c_o,
          bus1.res_valid, bus1.res_d, bus1.res_id, bus1.busy);
      mon(1, bus3.gnt, bus3.a_o, bus3.b_o, bus3.c_o,
          bus3.res_valid, bus3.res_d, bus3.res_id, bus3.busy);
    end
  end

  task automatic chk_zero(input string nm);
    chk(0, {nm, "_gnt"}, bus1.gnt, 0);
    chk(0, {nm, "_abc"}, {bus1.a_o, bus1.b_o, bus1.c_o}, 0);
    chk(0, {nm, "_rv"}, bus1.res_valid, 0);
    chk(0, {nm, "_rd"}, bus1.res_d, 0);
    chk(0, {nm, "_rid"}, bus1.res_id, 0);
    chk(0, {nm, "_busy"}, bus1.busy, 0);
    chk(1, {nm, "_gnt"}, bus3.gnt, 0);
    chk(1, {nm, "_abc"}, {bus3.a_o, bus3.b_o, bus3.c_o}, 0);
    chk(1, {nm, "_rv"}, bus3.res_valid, 0);
    chk(1, {nm, "_rd"}, bus3.res_d, 0);
    chk(1, {nm, "_rid"}, bus3.res_id, 0);
    chk(1, {nm, "_busy"}, bus3.busy, 0);
  endtask

  task automatic model_reset();
    gq0.delete();
    gq1.delete();
    rq0.delete();
    rq1.delete();
    m_left = '{0, 0};
    m_last = '{2, 2};
  endtask

  logic [2:0] fair_exp[4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst    = 1'b0;
    req_s  = 3'b000;
    opnd_s = 9'd0;
    #2 rst = 1'b1;
    #1 chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // single request, operands a=1 b=0 c=1
    idle(3);
    drive(3'b010, 9'b000_101_000);
    chk(0, "single_gnt", bus1.gnt, 3'b010);
    chk(0, "single_abc", {bus1.a_o, bus1.b_o, bus1.c_o}, 3'b101);
    drive(3'b000, 9'd0);
    chk(0, "single_rv", bus1.res_valid, 1);
    chk(0, "single_rd", bus1.res_d, 1);
    chk(0, "single_rid", bus1.res_id, 1);
    idle(5);

    // zero result on requester 0
    drive(3'b001, 9'b000_000_110);
    drive(3'b000, 9'd0);
    chk(0, "zero_rv", bus1.res_valid, 1);
    chk(0, "zero_rd", bus1.res_d, 0);
    chk(0, "zero_rid", bus1.res_id, 0);
    idle(5);
    chk(0, "zero_hold", bus1.res_d, 0);

    // long settle on requester 2
    drive(3'b100, 9'b011_000_000);
    chk(1, "settle_gnt0", bus3.gnt, 3'b100);
    drive(3'b000, 9'd0);
    drive(3'b000, 9'd0);
    chk(1, "settle_gnt2", bus3.gnt, 3'b100);
    chk(1, "settle_norv", bus3.res_valid, 0);
    drive(3'b000, 9'd0);
    chk(1, "settle_rv", bus3.res_valid, 1);
    chk(1, "settle_rd", bus3.res_d, 1);
    chk(1, "settle_rid", bus3.res_id, 2);
    idle(5);

    // request arriving during DRIVE waits, then goes back-to-back
    drive(3'b001, 9'($urandom));
    drive(3'b010, 9'($urandom));
    chk(0, "b2b_rv", bus1.res_valid, 1);
    chk(0, "b2b_gnt_idle", bus1.gnt, 0);
    drive(3'b010, 9'($urandom));
    chk(0, "b2b_gnt", bus1.gnt, 3'b010);
    idle(8);

    // asynchronous reset in the middle of DRIVE
    drive(3'b001, 9'($urandom));
    rst   = 1'b1;
    req_s = 3'b000;
    #1 chk_zero("abort");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // fairness restarts at requester 0
    for (int i = 0; i < 8; i++) begin
      drive(3'b111, 9'($urandom));
      if (i % 2 == 0) chk(0, "fair_gnt", bus1.gnt, fair_exp[i / 2]);
    end
    idle(6);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) drive(3'b000, 9'($urandom));
      else drive(3'($urandom), 9'($urandom));
    end
    idle(10);

    chk(0, "drain_gq", gq0.size(), 0);
    chk(0, "drain_rq", rq0.size(), 0);
    chk(1, "drain_gq", gq1.size(), 0);
    chk(1, "drain_rq", rq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
